// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared core definitions for the RV32I decode stage: ALU operation codes,
// major opcode constants, funct7 patterns, the immediate-format enum and the
// raw immediate extractor.
// -----------------------------------------------------------------------------
package decode_stage_pkg;

   // ALU operation codes, {instr[30], funct3} for the register/immediate forms.
   typedef enum logic [3:0] {
      AluAdd  = 4'b0000,
      AluSll  = 4'b0001,
      AluSlt  = 4'b0010,
      AluSltu = 4'b0011,
      AluXor  = 4'b0100,
      AluSrl  = 4'b0101,
      AluOr   = 4'b0110,
      AluAnd  = 4'b0111,
      AluSub  = 4'b1000,
      AluSra  = 4'b1101
   } alu_op_e;

   // Major opcodes (instr[6:0]) handled by this stage.
   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;

   // Legal funct7 patterns.
   localparam logic [6:0] Funct7Base = 7'b0000000;
   localparam logic [6:0] Funct7Alt  = 7'b0100000;

   typedef enum logic [1:0] {
      ImmFmtI,
      ImmFmtS,
      ImmFmtU
   } imm_fmt_e;

   // 32-bit immediate in the selected format, already sign-extended from
   // instr[31] to 32 bits (U-format has its low 12 bits zero).
   function automatic logic [31:0] imm_extract(input logic [31:0] instr,
                                               input imm_fmt_e    fmt);
      logic [31:0] imm;
      case (fmt)
         ImmFmtS: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         ImmFmtU: imm = {instr[31:12], 12'b0};
         default: imm = {{20{instr[31]}}, instr[31:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32I instruction-to-ALU-control decoder.
//
// Ports:
//   instr_i     instruction word
//   imm_o       sign-extended immediate (XLEN)
//   imm_sel_o   1 = ALU operand B takes the immediate
//   op_o        4-bit ALU operation code
//   rs1_addr_o  source 1 register address
//   rs2_addr_o  source 2 register address
//   rd_addr_o   destination register address
//   rd_wen_o    destination write enable (0 for x0 and illegal encodings)
//   mem_rd_o    load
//   mem_wr_o    store
//   illegal_o   unsupported encoding (present only with DECODE_ILLEGAL_EN)
//
// Configuration macro: DECODE_ILLEGAL_EN adds the illegal_o flag. Without it
// unsupported encodings still decode as a NOP (Add, no register or memory
// writes); only the flag itself is dropped.
// -----------------------------------------------------------------------------
module decode_comb
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [31:0]       instr_i,
   output logic [XLEN-1:0]   imm_o,
   output logic              imm_sel_o,
   output logic [3:0]        op_o,
   output logic [REG_AW-1:0] rs1_addr_o,
   output logic [REG_AW-1:0] rs2_addr_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              rd_wen_o,
   output logic              mem_rd_o,
`ifdef DECODE_ILLEGAL_EN
   output logic              mem_wr_o,
   output logic              illegal_o
`else
   output logic              mem_wr_o
`endif
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   imm_fmt_e   fmt;
   logic       bad;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign rs2_addr_o = instr_i[20 +: REG_AW];
   assign rd_addr_o  = instr_i[7 +: REG_AW];
   assign imm_o      = XLEN'($signed(imm_extract(instr_i, fmt)));

   always_comb begin
      fmt        = ImmFmtI;
      imm_sel_o  = 1'b0;
      op_o       = AluAdd;
      rs1_addr_o = instr_i[15 +: REG_AW];
      rd_wen_o   = 1'b0;
      mem_rd_o   = 1'b0;
      mem_wr_o   = 1'b0;
      bad        = 1'b0;

      case (opcode)
         OpcOp: begin
            op_o     = {instr_i[30], funct3};
            rd_wen_o = 1'b1;
            // The alternate funct7 only exists for SUB and SRA.
            if (funct7 == Funct7Alt)
               bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
            else if (funct7 != Funct7Base)
               bad = 1'b1;
         end
         OpcOpImm: begin
            imm_sel_o = 1'b1;
            rd_wen_o  = 1'b1;
            // instr[30] is part of the immediate except for the right shifts,
            // where it selects SRAI over SRLI.
            op_o = (funct3 == 3'b101) ? {instr_i[30], funct3} : {1'b0, funct3};
            if (funct3 == 3'b001)
               bad = (funct7 != Funct7Base);
            else if (funct3 == 3'b101)
               bad = (funct7 != Funct7Base) && (funct7 != Funct7Alt);
         end
         OpcLui: begin
            rs1_addr_o = '0;
            fmt        = ImmFmtU;
            imm_sel_o  = 1'b1;
            rd_wen_o   = 1'b1;
         end
         OpcLoad: begin
            imm_sel_o = 1'b1;
            mem_rd_o  = 1'b1;
            rd_wen_o  = 1'b1;
         end
         OpcStore: begin
            fmt       = ImmFmtS;
            imm_sel_o = 1'b1;
            mem_wr_o  = 1'b1;
         end
         default: bad = 1'b1;
      endcase

      // Unsupported encodings become a side-effect-free Add.
      if (bad) begin
         op_o     = AluAdd;
         rd_wen_o = 1'b0;
         mem_rd_o = 1'b0;
         mem_wr_o = 1'b0;
      end

      if (rd_addr_o == '0)
         rd_wen_o = 1'b0;
   end

`ifdef DECODE_ILLEGAL_EN
   assign illegal_o = bad;
`endif

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode pipeline stage between fetch and execute. Accepts
// instructions over a valid/ready handshake, decodes them with decode_comb and
// holds the result in a single pipeline register for the execute stage.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_if_valid/o_if_ready, i_if_instr, i_if_pc   fetch-side handshake
//   i_flush             kill held and incoming instruction
//   o_id_valid/i_ex_ready                        execute-side handshake
//   o_id_pc, o_id_imm, o_id_imm_sel, o_id_op_data,
//   o_id_rs1_addr, o_id_rs2_addr, o_id_rd_addr   decoded payload
//   o_id_rd_wen, o_id_mem_rd, o_id_mem_wr        side effects, gated by valid
//   o_id_illegal        unsupported encoding
//
// Configuration macro: DECODE_ILLEGAL_EN drives o_id_illegal; without it the
// output is tied 0 and no illegal register exists.
// -----------------------------------------------------------------------------
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_valid,
   output logic              o_if_ready,
   input  logic [31:0]       i_if_instr,
   input  logic [XLEN-1:0]   i_if_pc,
   input  logic              i_flush,
   output logic              o_id_valid,
   input  logic              i_ex_ready,
   output logic [XLEN-1:0]   o_id_pc,
   output logic [XLEN-1:0]   o_id_imm,
   output logic              o_id_imm_sel,
   output logic [3:0]        o_id_op_data,
   output logic [REG_AW-1:0] o_id_rs1_addr,
   output logic [REG_AW-1:0] o_id_rs2_addr,
   output logic [REG_AW-1:0] o_id_rd_addr,
   output logic              o_id_rd_wen,
   output logic              o_id_mem_rd,
   output logic              o_id_mem_wr,
   output logic              o_id_illegal
);

   logic [XLEN-1:0]   dec_imm;
   logic              dec_imm_sel;
   logic [3:0]        dec_op;
   logic [REG_AW-1:0] dec_rs1;
   logic [REG_AW-1:0] dec_rs2;
   logic [REG_AW-1:0] dec_rd;
   logic              dec_rd_wen;
   logic              dec_mem_rd;
   logic              dec_mem_wr;

   logic              valid_q, valid_d;
   logic              load;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   imm_q;
   logic              imm_sel_q;
   logic [3:0]        op_q;
   logic [REG_AW-1:0] rs1_q;
   logic [REG_AW-1:0] rs2_q;
   logic [REG_AW-1:0] rd_q;
   logic              rd_wen_q;
   logic              mem_rd_q;
   logic              mem_wr_q;

`ifdef DECODE_ILLEGAL_EN
   logic              dec_illegal;
   logic              illegal_q;
`endif

   decode_comb #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_decode_comb (
      .instr_i    (i_if_instr),
      .imm_o      (dec_imm),
      .imm_sel_o  (dec_imm_sel),
      .op_o       (dec_op),
      .rs1_addr_o (dec_rs1),
      .rs2_addr_o (dec_rs2),
      .rd_addr_o  (dec_rd),
      .rd_wen_o   (dec_rd_wen),
      .mem_rd_o   (dec_mem_rd),
`ifdef DECODE_ILLEGAL_EN
      .mem_wr_o   (dec_mem_wr),
      .illegal_o  (dec_illegal)
`else
      .mem_wr_o   (dec_mem_wr)
`endif
   );

   assign o_if_ready = !valid_q || i_ex_ready;
   assign load       = i_if_valid && o_if_ready && !i_flush;

   // Flush beats load and stall; without a load a consumed entry empties.
   always_comb begin
      valid_d = valid_q;
      if (i_flush)
         valid_d = 1'b0;
      else if (load)
         valid_d = 1'b1;
      else if (i_ex_ready)
         valid_d = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         imm_q     <= '0;
         imm_sel_q <= 1'b0;
         op_q      <= AluAdd;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         rd_wen_q  <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            pc_q      <= i_if_pc;
            imm_q     <= dec_imm;
            imm_sel_q <= dec_imm_sel;
            op_q      <= dec_op;
            rs1_q     <= dec_rs1;
            rs2_q     <= dec_rs2;
            rd_q      <= dec_rd;
            rd_wen_q  <= dec_rd_wen;
            mem_rd_q  <= dec_mem_rd;
            mem_wr_q  <= dec_mem_wr;
         end
      end
   end

`ifdef DECODE_ILLEGAL_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         illegal_q <= 1'b0;
      else if (load)
         illegal_q <= dec_illegal;
   end
   assign o_id_illegal = illegal_q;
`else
   assign o_id_illegal = 1'b0;
`endif

   assign o_id_valid    = valid_q;
   assign o_id_pc       = pc_q;
   assign o_id_imm      = imm_q;
   assign o_id_imm_sel  = imm_sel_q;
   assign o_id_op_data  = op_q;
   assign o_id_rs1_addr = rs1_q;
   assign o_id_rs2_addr = rs2_q;
   assign o_id_rd_addr  = rd_q;
   // Side-effect controls must never fire from a stale payload.
   assign o_id_rd_wen   = valid_q && rd_wen_q;
   assign o_id_mem_rd   = valid_q && mem_rd_q;
   assign o_id_mem_wr   = valid_q && mem_wr_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Table of instructions with hand-derived decode results, streamed through
// decode_stage; a queue scoreboard tracks what the stage should be holding.
// Hand-written sequences cover stall, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_valid;
   logic        ex_ready;
   logic [31:0] id_pc;
   logic [31:0] id_imm;
   logic        id_imm_sel;
   logic [3:0]  id_op;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rd_wen, id_mem_rd, id_mem_wr, id_illegal;

   always #5 clk = ~clk;

   decode_stage #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_if_valid    (if_valid),
      .o_if_ready    (if_ready),
      .i_if_instr    (if_instr),
      .i_if_pc       (if_pc),
      .i_flush       (flush),
      .o_id_valid    (id_valid),
      .i_ex_ready    (ex_ready),
      .o_id_pc       (id_pc),
      .o_id_imm      (id_imm),
      .o_id_imm_sel  (id_imm_sel),
      .o_id_op_data  (id_op),
      .o_id_rs1_addr (id_rs1),
      .o_id_rs2_addr (id_rs2),
      .o_id_rd_addr  (id_rd),
      .o_id_rd_wen   (id_rd_wen),
      .o_id_mem_rd   (id_mem_rd),
      .o_id_mem_wr   (id_mem_wr),
      .o_id_illegal  (id_illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic        sel;
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wen;
      logic        mrd;
      logic        mwr;
      logic        ill;
      logic        chk_imm;
      logic        chk_rs2;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] pc;
   } exp_t;

   localparam int NV = 14;
   vec_t vec [NV];
   exp_t q [$];

   int tests = 0;
   int fails = 0;
   int accepted = 0;
   int consumed = 0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                               input logic sel, input logic [3:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic wen,
                               input logic mrd, input logic mwr, input logic ill,
                               input logic chk_imm, input logic chk_rs2);
      vec_t v;
      v.instr = instr; v.imm = imm; v.sel = sel; v.op = op;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen;
      v.mrd = mrd; v.mwr = mwr;
`ifdef DECODE_ILLEGAL_EN
      v.ill = ill;
`else
      v.ill = 1'b0 & ill;
`endif
      v.chk_imm = chk_imm; v.chk_rs2 = chk_rs2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_held(input exp_t e);
      check("pc",      id_pc,                e.pc);
      check("op",      32'(id_op),           32'(e.v.op));
      check("imm_sel", 32'(id_imm_sel),      32'(e.v.sel));
      check("rs1",     32'(id_rs1),          32'(e.v.rs1));
      check("rd",      32'(id_rd),           32'(e.v.rd));
      check("rd_wen",  32'(id_rd_wen),       32'(e.v.wen));
      check("mem_rd",  32'(id_mem_rd),       32'(e.v.mrd));
      check("mem_wr",  32'(id_mem_wr),       32'(e.v.mwr));
      check("illegal", 32'(id_illegal),      32'(e.v.ill));
      if (e.v.chk_imm) check("imm", id_imm, e.v.imm);
      if (e.v.chk_rs2) check("rs2", 32'(id_rs2), 32'(e.v.rs2));
   endtask

   // Evaluated between edges with this cycle's inputs applied: checks what the
   // stage presents, then advances the model to the state after the next edge.
   task automatic sb_step(input int idx);
      logic rdy;
      exp_t e;
      rdy = (q.size() == 0) || ex_ready;
      check("if_ready", 32'(if_ready), 32'(rdy));
      check("id_valid", 32'(id_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         compare_held(q[0]);
         if (ex_ready) begin
            void'(q.pop_front());
            consumed++;
         end else if (flush) begin
            void'(q.pop_front());
         end
      end else begin
         check("gated_side_effects", {29'b0, id_rd_wen, id_mem_rd, id_mem_wr}, 32'b0);
      end
      if (if_valid && rdy && !flush) begin
         e.v  = vec[idx];
         e.pc = if_pc;
         q.push_back(e);
         accepted++;
         pc_ctr += 32'd4;
      end
   endtask

   task automatic drive(input logic v, input int idx, input logic exr, input logic fl);
      @(negedge clk);
      if_valid = v;
      if_instr = vec[idx].instr;
      if_pc    = pc_ctr;
      ex_ready = exr;
      flush    = fl;
      #1;
      sb_step(idx);
   endtask

   initial begin
      //          instr          imm           sel op       rs1 rs2 rd  wen mrd mwr ill ci cr2
      vec[0]  = mk(32'hFFD08293, 32'hFFFFFFFD, 1, 4'b0000, 1,  0,  5,  1,  0,  0,  0,  1, 0); // addi x5,x1,-3
      vec[1]  = mk(32'h402081B3, 32'h0,        0, 4'b1000, 1,  2,  3,  1,  0,  0,  0,  0, 1); // sub x3,x1,x2
      vec[2]  = mk(32'h40225213, 32'h00000402, 1, 4'b1101, 4,  0,  4,  1,  0,  0,  0,  1, 0); // srai x4,x4,2
      vec[3]  = mk(32'h0020A423, 32'h00000008, 1, 4'b0000, 1,  2,  8,  0,  0,  1,  0,  1, 1); // sw x2,8(x1)
      vec[4]  = mk(32'h123453B7, 32'h12345000, 1, 4'b0000, 0,  0,  7,  1,  0,  0,  0,  1, 0); // lui x7,0x12345
      vec[5]  = mk(32'hFFC12303, 32'hFFFFFFFC, 1, 4'b0000, 2,  0,  6,  1,  1,  0,  0,  1, 0); // lw x6,-4(x2)
      vec[6]  = mk(32'h00208033, 32'h0,        0, 4'b0000, 1,  2,  0,  0,  0,  0,  0,  0, 1); // add x0,x1,x2
      vec[7]  = mk(32'h000002FF, 32'h0,        0, 4'b0000, 0,  0,  5,  0,  0,  0,  1,  0, 0); // opcode 0x7F
      vec[8]  = mk(32'h022080B3, 32'h0,        0, 4'b0000, 1,  2,  1,  0,  0,  0,  1,  0, 0); // OP funct7=0000001
      vec[9]  = mk(32'h402091B3, 32'h0,        0, 4'b0000, 1,  2,  3,  0,  0,  0,  1,  0, 0); // OP alt funct7, funct3=001
      vec[10] = mk(32'h40209193, 32'h0,        1, 4'b0000, 1,  0,  3,  0,  0,  0,  1,  0, 0); // slli bad funct7
      vec[11] = mk(32'hFFF0C493, 32'hFFFFFFFF, 1, 4'b0100, 1,  0,  9,  1,  0,  0,  0,  1, 0); // xori x9,x1,-1
      vec[12] = mk(32'h407352B3, 32'h0,        0, 4'b1101, 6,  7,  5,  1,  0,  0,  0,  0, 1); // sra x5,x6,x7
      vec[13] = mk(32'h0020B433, 32'h0,        0, 4'b0011, 1,  2,  8,  1,  0,  0,  0,  0, 1); // sltu x8,x1,x2

      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
      #1;
      check("reset_valid",   32'(id_valid), 32'd0);
      check("reset_ready",   32'(if_ready), 32'd1);
      check("reset_payload", id_imm | id_pc | 32'(id_op), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back stream of the whole table.
      for (int i = 0; i < NV; i++) drive(1'b1, i, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);

      // Stall for 3 cycles with fetch holding the next instruction.
      drive(1'b1, 1, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) drive(1'b1, 2, 1'b0, 1'b0);
      drive(1'b1, 2, 1'b1, 1'b0);
      drive(1'b1, 3, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);

      // Flush while holding a stalled entry and presenting a new one.
      drive(1'b1, 4, 1'b1, 1'b0);
      drive(1'b1, 5, 1'b0, 1'b1);
      drive(1'b0, 0, 1'b1, 1'b0);
      // Flush into an empty stage drops the incoming instruction.
      drive(1'b1, 11, 1'b1, 1'b1);
      drive(1'b1, 12, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);

      // Asynchronous reset while stalled: outputs clear before any edge.
      drive(1'b1, 5, 1'b1, 1'b0);
      drive(1'b1, 0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid",  32'(id_valid), 32'd0);
      check("async_rst_ready",  32'(if_ready), 32'd1);
      check("async_rst_sidefx", {29'b0, id_rd_wen, id_mem_rd, id_mem_wr}, 32'd0);
      check("async_rst_payload", id_imm | id_pc | 32'({id_op, id_rd, id_rs1}), 32'd0);
      q.delete();
      accepted = consumed;
      @(negedge clk);
      rst = 1'b0;
      if_valid = 1'b0;
      drive(1'b1, 13, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);

      check("scoreboard_drained", 32'(q.size()), 32'd0);
      check("no_loss_or_dup", 32'(consumed), 32'(accepted));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage. It sits between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and decodes each into ALU controls: 4-bit op, immediate, immediate-select, register addresses and write-enable.
- Presents the decoded result as one pipeline register to the execute stage. It is the producer side of the ALU control/operand interface.

Parameters:
XLEN, 32, datapath and immediate width
REG_AW, 5, register-file address width

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_if_valid  input  1  fetch presents an instruction
o_if_ready  output  1  stage can accept this cycle
i_if_instr  input  32  instruction word
i_if_pc  input  XLEN  instruction address
i_flush  input  1  kill held and incoming instruction
o_id_valid  output  1  decoded result valid
i_ex_ready  input  1  execute accepts result
o_id_pc  output  XLEN  registered PC
o_id_imm  output  XLEN  sign-extended immediate
o_id_imm_sel  output  1  1 = ALU B takes immediate
o_id_op_data  output  4  ALU operation code
o_id_rs1_addr  output  REG_AW  source 1 address
o_id_rs2_addr  output  REG_AW  source 2 address
o_id_rd_addr  output  REG_AW  destination address
o_id_rd_wen  output  1  destination write enable
o_id_mem_rd  output  1  load
o_id_mem_wr  output  1  store
o_id_illegal  output  1  unsupported encoding

Behaviour:
- Reset, asynchronous: all outputs 0, including o_id_valid=0. o_if_ready follows its equation, so it reads 1 immediately.
- Ready: o_if_ready = !o_id_valid || i_ex_ready. This is combinational and has no dependency on i_if_valid.
- Load: when i_if_valid && o_if_ready && !i_flush, the register captures the decode of i_if_instr on the next edge and sets o_id_valid=1. Latency is 1 cycle.
- Drain: when o_id_valid && i_ex_ready and no load occurs, o_id_valid clears. Simultaneous drain and load gives back-to-back throughput of 1/cycle.
- Stall: when o_id_valid && !i_ex_ready, all o_id_* outputs hold stable.
- Flush: i_flush forces o_id_valid=0 next edge and drops any incoming instruction. Flush wins over load and stall.
- Payload when o_id_valid=0 is don't-care. However, o_id_rd_wen, o_id_mem_rd and o_id_mem_wr are gated to 0.
- Opcode decode:
  - OP 0110011: imm_sel=0; op={instr[30],funct3}; rd_wen=1.
  - OP-IMM 0010011: imm_sel=1, I-imm. op={instr[30],funct3} for funct3=101, else {0,funct3}.
  - LUI 0110111: rs1_addr=0, U-imm, op=Add, imm_sel=1, rd_wen=1.
  - LOAD 0000011: I-imm, Add, imm_sel=1, mem_rd=1, rd_wen=1.
  - STORE 0100011: S-imm, Add, imm_sel=1, mem_wr=1, rd_wen=0.
- Immediates are sign-extended from instr[31]. U-imm = {instr[31:12],12'b0}.
- Illegal encodings:
  - any other opcode;
  - OP with funct7 not in {0000000, 0100000};
  - OP funct7=0100000 with funct3 not in {000, 101};
  - OP-IMM shift (funct3 001/101) with a bad funct7.
- Illegal instructions: rd_wen=0, mem_rd=0, mem_wr=0, op=Add, o_id_illegal=1.
- rd_addr=0 forces rd_wen=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: o_id_illegal is driven as above.
- Undefined: o_id_illegal is tied 0 and its detection logic is omitted. Illegal encodings still decode as a NOP: Add, rd_wen=0, mem_rd=0, mem_wr=0.

Decomposition:
- Shared core package holds the ALU op constants:
  - AluAdd=0000, AluSub=1000, AluSll=0001, AluSlt=0010, AluSltu=0011;
  - AluXor=0100, AluSrl=0101, AluSra=1101, AluOr=0110, AluAnd=0111.
- The same package holds the opcode constants and the immediate-format enum (I/S/U).
- One natural sub-module: decode_comb, a purely combinational instr-to-fields decoder. decode_stage adds the handshake and pipeline register.

Test Plan:
- Reset, then addi x5,x1,-3 (0xFFD08293) with ex_ready=1 → next cycle valid=1, imm=0xFFFFFFFD, imm_sel=1, op=0000, rd=5, rd_wen=1.
- sub x3,x1,x2 (0x402081B3) → op=1000, imm_sel=0, rs1=1, rs2=2, rd=3.
- ex_ready=0 for 3 cycles with the fetch stream valid → o_if_ready=0, outputs stable. Release → next instruction appears the following cycle with no loss or duplication.
- srai x4,x4,2 (0x40225213) → op=1101, imm low 5 bits=2; sw x2,8(x1) (0x0020A423) → imm=8, mem_wr=1, rd_wen=0.
- i_flush asserted with valid held and an incoming instruction → o_id_valid=0 next cycle; the held instruction never reaches execute.
- Opcode 0x7F with DECODE_ILLEGAL_EN defined → illegal=1, rd_wen=0. Undefined → illegal=0, rd_wen=0.
- Async reset mid-stall → outputs 0 immediately, without waiting for a clock edge.
